alarm_zone_ctrl: RTL
====================

ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 Parameter N_ZONES, default 4: number of alarm zones, legal range 1..16.
REQ-002 Parameter CNT_W, default 8: width of the warning and ventilation counters.
REQ-003 Parameter WARN_CYC, default 16: maximum cycles spent in ARM with aviso held, legal range 1..2^CNT_W-1.
REQ-004 Parameter VENT_HOLD, default 32: minimum cycles spent in VNT, legal range 1..2^CNT_W-1.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-007 EN  in  1  system enable; 1 arms the system, 0 disarms it from any state.
REQ-008 aviso  in  1  pre-arm warning condition, such as a door open.
REQ-009 zone_in  in  N_ZONES  raw per-zone alarm sensors, active-high.
REQ-010 zone_mask  in  N_ZONES  per-zone enable; a zone is active only when zone_in and zone_mask are both 1.
REQ-011 vent  in  1  ventilation request.
REQ-012 ack  in  1  operator acknowledge.
REQ-013 alarm_int  out  1  internal warning indicator.
REQ-014 alarm_ext  out  1  external siren.
REQ-015 venti  out  1  ventilation drive.
REQ-016 salida  out  3  current state code.
REQ-017 zone_lat  out  N_ZONES  latched zones that have triggered since the last clear.
REQ-018 timeout  out  1  sticky flag: arming was aborted by warning timeout.

Function
REQ-019 All outputs SHALL be registered and SHALL update on the same clk edge as the state register.
REQ-020 State codes SHALL be: DIS=000, ARM=001, MON=010, ALM=011, VNT=100.
REQ-021 salida SHALL equal the code of the current state; codes 101..111 are unreachable, and any of them SHALL return to DIS on the next edge.
REQ-022 Define active = zone_in & zone_mask, evaluated every cycle.
REQ-023 DIS: alarm_int=0, alarm_ext=0, venti=0; EN=1 -> ARM; warn counter cleared on entry.
REQ-024 ARM: alarm_int=1; aviso=0 -> MON.
REQ-025 ARM: while aviso=1, the warn counter increments each cycle; when it reaches WARN_CYC-1 with aviso=1 -> DIS and timeout set to 1.
REQ-026 timeout SHALL remain 1 until a cycle with EN=0; the transition DIS->ARM SHALL NOT occur while timeout=1.
REQ-027 MON: alarm_int=0; active!=0 -> ALM, with zone_lat <= zone_lat | active on the same edge.
REQ-028 ALM: alarm_ext=1; zone_lat ORs in active every cycle.
REQ-029 ALM: vent=1 -> VNT, with the vent counter loaded to VENT_HOLD-1.
REQ-030 ALM: ack=1 and active==0 and vent=0 -> MON, with zone_lat cleared to 0.
REQ-031 ALM: if vent=1 and ack=1 arrive in the same cycle, vent SHALL win.
REQ-032 ALM: ack=1 while active!=0 SHALL be ignored.
REQ-033 VNT: alarm_ext=1, venti=1; the vent counter decrements to 0 and holds there; zone_lat keeps accumulating.
REQ-034 VNT: vent counter==0 and active==0 -> DIS, with zone_lat cleared; VNT SHALL be occupied for at least VENT_HOLD cycles.
REQ-035 From any state other than DIS, EN=0 SHALL force DIS on the next edge, overriding all other transitions; zone_lat and both counters are cleared.
REQ-036 Counters SHALL saturate and never wrap.
REQ-037 With N_ZONES=1, behaviour SHALL degenerate to a single-sensor controller with identical state timing.

Reset
REQ-038 On a clk edge with reset=0: state=DIS, alarm_int=alarm_ext=venti=0, salida=000, zone_lat=0, timeout=0, counters=0.
REQ-039 Reset SHALL override EN and all other inputs, including when asserted mid-ALM or mid-VNT.
REQ-040 The first transition after reset release SHALL follow REQ-023.

Verification
REQ-041 Arm path: EN=1, aviso=0 -> salida 000->001->010 on consecutive edges; alarm_int=1 for exactly 1 cycle.
REQ-042 Warn timeout, WARN_CYC=4: EN=1, aviso=1 held -> 4 cycles in ARM, then DIS with timeout=1; EN stays 1 -> remains DIS; EN=0 then EN=1 -> timeout=0 and ARM entered.
REQ-043 Masked zone: zone_mask=4'b0101, zone_in=4'b0010 -> stays MON; zone_in=4'b0100 -> ALM, zone_lat=4'b0100, alarm_ext=1.
REQ-044 ALM contention: vent=1 and ack=1 in the same cycle -> VNT; with VENT_HOLD=3 and active=0 -> exactly 3 cycles in VNT (venti=1), then DIS with zone_lat=0.
REQ-045 Ack rules: in ALM, ack=1 while active!=0 -> stays ALM; active=0 then ack=1 -> MON with zone_lat=0.
REQ-046 Abort and reset: EN=0 in VNT -> DIS next edge with all outputs 0; reset=0 asserted in ALM -> all outputs 0 on that edge.

Source files
------------

// File: rtl/alarm_zone_ctrl.sv
// Alarm zone controller: arming with warning timeout, zone monitoring with
// per-zone latch, alarm acknowledge and a minimum-hold ventilation phase.
module alarm_zone_ctrl #(
  parameter int unsigned N_ZONES   = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned WARN_CYC  = 16,
  parameter int unsigned VENT_HOLD = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EN,
  input  logic               aviso,
  input  logic [N_ZONES-1:0] zone_in,
  input  logic [N_ZONES-1:0] zone_mask,
  input  logic               vent,
  input  logic               ack,
  output logic               alarm_int,
  output logic               alarm_ext,
  output logic               venti,
  output logic [2:0]         salida,
  output logic [N_ZONES-1:0] zone_lat,
  output logic               timeout
);

  typedef enum logic [2:0] {
    StDis = 3'b000,
    StArm = 3'b001,
    StMon = 3'b010,
    StAlm = 3'b011,
    StVnt = 3'b100
  } state_e;

  localparam logic [CNT_W-1:0] WarnLast = CNT_W'(WARN_CYC - 1);
  localparam logic [CNT_W-1:0] VentLoad = CNT_W'(VENT_HOLD - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   warn_cnt_q, warn_cnt_d;
  logic [CNT_W-1:0]   vent_cnt_q, vent_cnt_d;
  logic [N_ZONES-1:0] lat_q, lat_d;
  logic               timeout_q, timeout_d;
  logic               alarm_int_q, alarm_int_d;
  logic               alarm_ext_q, alarm_ext_d;
  logic               venti_q, venti_d;
  logic [N_ZONES-1:0] active;

  assign active = zone_in & zone_mask;

  // Next-state, counter and latch update; outputs are decoded from the next state
  // so they register on the same edge as the state itself.
  always_comb begin
    state_d    = state_q;
    warn_cnt_d = warn_cnt_q;
    vent_cnt_d = vent_cnt_q;
    lat_d      = lat_q;
    timeout_d  = timeout_q;

    if (!EN) begin
      // Disarm overrides everything; an EN=0 cycle also releases the timeout flag.
      state_d    = StDis;
      warn_cnt_d = '0;
      vent_cnt_d = '0;
      lat_d      = '0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        StDis: begin
          warn_cnt_d = '0;
          if (!timeout_q) state_d = StArm;
        end
        StArm: begin
          if (!aviso) begin
            state_d = StMon;
          end else if (warn_cnt_q >= WarnLast) begin
            state_d    = StDis;
            timeout_d  = 1'b1;
            warn_cnt_d = '0;
          end else if (warn_cnt_q != '1) begin
            warn_cnt_d = warn_cnt_q + 1'b1;
          end
        end
        StMon: begin
          if (|active) begin
            state_d = StAlm;
            lat_d   = lat_q | active;
          end
        end
        StAlm: begin
          lat_d = lat_q | active;
          // Ventilation request wins over a simultaneous acknowledge.
          if (vent) begin
            state_d    = StVnt;
            vent_cnt_d = VentLoad;
          end else if (ack && !(|active)) begin
            state_d = StMon;
            lat_d   = '0;
          end
        end
        StVnt: begin
          lat_d = lat_q | active;
          if (vent_cnt_q != '0) begin
            vent_cnt_d = vent_cnt_q - 1'b1;
          end else if (!(|active)) begin
            state_d    = StDis;
            lat_d      = '0;
            warn_cnt_d = '0;
          end
        end
        default: begin
          // Unused codes recover to a clean disarmed state.
          state_d    = StDis;
          warn_cnt_d = '0;
          vent_cnt_d = '0;
          lat_d      = '0;
        end
      endcase
    end

    alarm_int_d = (state_d == StArm);
    alarm_ext_d = (state_d == StAlm) || (state_d == StVnt);
    venti_d     = (state_d == StVnt);
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StDis;
      warn_cnt_q  <= '0;
      vent_cnt_q  <= '0;
      lat_q       <= '0;
      timeout_q   <= 1'b0;
      alarm_int_q <= 1'b0;
      alarm_ext_q <= 1'b0;
      venti_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      warn_cnt_q  <= warn_cnt_d;
      vent_cnt_q  <= vent_cnt_d;
      lat_q       <= lat_d;
      timeout_q   <= timeout_d;
      alarm_int_q <= alarm_int_d;
      alarm_ext_q <= alarm_ext_d;
      venti_q     <= venti_d;
    end
  end

  assign alarm_int = alarm_int_q;
  assign alarm_ext = alarm_ext_q;
  assign venti     = venti_q;
  assign salida    = state_q;
  assign zone_lat  = lat_q;
  assign timeout   = timeout_q;

endmodule
